vgpr_retire_arbiter: RTL and testbench

//  Producer side of the VGPR retire interface into the issue-stage vgpr_comparator array.

---
 rtl/vgpr_retire_arbiter_pkg.sv | 23 ++
 rtl/vgpr_retire_fifo.sv | 64 ++++++
 rtl/vgpr_retire_arbiter.sv | 113 +++++++++++
 tb/tb_vgpr_retire_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vgpr_retire_arbiter_pkg.sv
// Shared types and constants for the VGPR retire path into the issue-stage comparators.
package vgpr_retire_arbiter_pkg;

  localparam int unsigned VGPR_ADDR_W = 10;
  localparam int unsigned WF_ID_W     = 6;
  localparam int unsigned MASK_W      = 4;

  localparam logic [MASK_W-1:0] MASK_NONE = 4'b0000;
  localparam logic [MASK_W-1:0] MASK_1W   = 4'b0001;
  localparam logic [MASK_W-1:0] MASK_2W   = 4'b0011;
  localparam logic [MASK_W-1:0] MASK_4W   = 4'b1111;

  typedef struct packed {
    logic [WF_ID_W-1:0]     wfid;
    logic [VGPR_ADDR_W-1:0] addr;
    logic [MASK_W-1:0]      mask;
  } retire_entry_t;

  function automatic logic mask_is_legal(input logic [MASK_W-1:0] mask);
    return (mask == MASK_1W) || (mask == MASK_2W) || (mask == MASK_4W);
  endfunction

endpackage

// File: rtl/vgpr_retire_fifo.sv
// Synchronous per-source retire FIFO; ready/full is derived from the registered count only.
module vgpr_retire_fifo
  import vgpr_retire_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  retire_entry_t          wdata_i,
  input  logic                   pop_i,
  output retire_entry_t          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  retire_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vgpr_retire_arbiter.sv
// Merges SIMD and LSU VGPR retire events into one registered {wfid, addr, mask} broadcast per cycle.
module vgpr_retire_arbiter
  import vgpr_retire_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = VGPR_ADDR_W,
  parameter int unsigned WFID_W = WF_ID_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              simd_retire_valid,
  output logic              simd_retire_ready,
  input  logic [WFID_W-1:0] simd_retire_wfid,
  input  logic [ADDR_W-1:0] simd_retire_addr,
  input  logic [3:0]        simd_retire_mask,
  input  logic              lsu_retire_valid,
  output logic              lsu_retire_ready,
  input  logic [WFID_W-1:0] lsu_retire_wfid,
  input  logic [ADDR_W-1:0] lsu_retire_addr,
  input  logic [3:0]        lsu_retire_mask,
  output logic              retired_operand_valid,
  output logic [WFID_W-1:0] retired_operand_wfid,
  output logic [ADDR_W-1:0] retired_operand_addr,
  output logic [3:0]        retired_operand_mask,
  output logic              retire_mask_error,
  output logic              retire_idle
);

  retire_entry_t         simd_wdata, lsu_wdata, simd_rdata, lsu_rdata;
  logic                  simd_full, simd_empty, lsu_full, lsu_empty;
  logic [$clog2(DEPTH):0] simd_count, lsu_count;
  logic                  simd_acc, lsu_acc, simd_push, lsu_push, simd_bad, lsu_bad;
  logic                  grant_simd, grant_lsu;
  logic                  last_lsu_q, last_lsu_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  retire_entry_t         out_q, out_d;

  assign simd_wdata = '{wfid: simd_retire_wfid, addr: simd_retire_addr, mask: simd_retire_mask};
  assign lsu_wdata  = '{wfid: lsu_retire_wfid,  addr: lsu_retire_addr,  mask: lsu_retire_mask};

  vgpr_retire_fifo #(.DEPTH(DEPTH)) u_simd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (simd_push),
    .wdata_i (simd_wdata),
    .pop_i   (grant_simd),
    .rdata_o (simd_rdata),
    .full_o  (simd_full),
    .empty_o (simd_empty),
    .count_o (simd_count)
  );

  vgpr_retire_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (lsu_push),
    .wdata_i (lsu_wdata),
    .pop_i   (grant_lsu),
    .rdata_o (lsu_rdata),
    .full_o  (lsu_full),
    .empty_o (lsu_empty),
    .count_o (lsu_count)
  );

  // Zero masks are accepted but never stored; other non-legal masks are stored and flagged.
  always_comb begin
    simd_acc  = simd_retire_valid && !simd_full;
    lsu_acc   = lsu_retire_valid && !lsu_full;
    simd_push = simd_acc && (simd_retire_mask != MASK_NONE);
    lsu_push  = lsu_acc && (lsu_retire_mask != MASK_NONE);
    simd_bad  = simd_push && !mask_is_legal(simd_retire_mask);
    lsu_bad   = lsu_push && !mask_is_legal(lsu_retire_mask);
    err_d     = simd_bad || lsu_bad;
  end

  // Round robin: on contention grant the source that did not win last time.
  always_comb begin
    grant_simd = !simd_empty && (lsu_empty || last_lsu_q);
    grant_lsu  = !lsu_empty && !grant_simd;
    last_lsu_d = last_lsu_q;
    if (grant_simd)     last_lsu_d = 1'b0;
    else if (grant_lsu) last_lsu_d = 1'b1;
    valid_d = grant_simd || grant_lsu;
    out_d   = '0;
    if (grant_simd)     out_d = simd_rdata;
    else if (grant_lsu) out_d = lsu_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_lsu_q <= 1'b1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      out_q      <= '0;
    end else begin
      last_lsu_q <= last_lsu_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      out_q      <= out_d;
    end
  end

  assign simd_retire_ready     = !simd_full;
  assign lsu_retire_ready      = !lsu_full;
  assign retired_operand_valid = valid_q;
  assign retired_operand_wfid  = out_q.wfid;
  assign retired_operand_addr  = out_q.addr;
  assign retired_operand_mask  = out_q.mask;
  assign retire_mask_error     = err_q;
  assign retire_idle           = (simd_count == '0) && (lsu_count == '0) && !valid_q;

endmodule

// File: tb/tb_vgpr_retire_arbiter.sv
// Directed bench for vgpr_retire_arbiter with a per-source expected-entry scoreboard.
module tb_vgpr_retire_arbiter;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       simd_v = 1'b0, lsu_v = 1'b0;
  logic [5:0] simd_wf = '0, lsu_wf = '0;
  logic [9:0] simd_a = '0, lsu_a = '0;
  logic [3:0] simd_m = '0, lsu_m = '0;
  logic       simd_rdy, lsu_rdy, o_valid, o_err, o_idle;
  logic [5:0] o_wfid;
  logic [9:0] o_addr;
  logic [3:0] o_mask;

  vgpr_retire_arbiter #(.ADDR_W(10), .WFID_W(6), .DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .simd_retire_valid     (simd_v),
    .simd_retire_ready     (simd_rdy),
    .simd_retire_wfid      (simd_wf),
    .simd_retire_addr      (simd_a),
    .simd_retire_mask      (simd_m),
    .lsu_retire_valid      (lsu_v),
    .lsu_retire_ready      (lsu_rdy),
    .lsu_retire_wfid       (lsu_wf),
    .lsu_retire_addr       (lsu_a),
    .lsu_retire_mask       (lsu_m),
    .retired_operand_valid (o_valid),
    .retired_operand_wfid  (o_wfid),
    .retired_operand_addr  (o_addr),
    .retired_operand_mask  (o_mask),
    .retire_mask_error     (o_err),
    .retire_idle           (o_idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] wf;
    logic [9:0] a;
    logic [3:0] m;
  } ent_t;

  ent_t       qs[$];
  ent_t       ql[$];
  ent_t       m_out = '0;
  logic       m_valid = 1'b0, m_err = 1'b0, m_last_lsu = 1'b1;
  logic       s_acc, l_acc, g_s, g_l;
  logic [9:0] dut_log[$];
  int         checks = 0, failures = 0;
  logic       chk_en = 1'b0;

  function automatic logic legal(input logic [3:0] m);
    return (m == 4'b0001) || (m == 4'b0011) || (m == 4'b1111);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected entries are queued at accept and popped by the modelled arbiter.
  always @(posedge clk) begin
    if (!rst_n) begin
      qs.delete();
      ql.delete();
      m_last_lsu = 1'b1;
      m_valid    = 1'b0;
      m_err      = 1'b0;
      m_out      = '0;
    end else begin
      s_acc   = simd_v && (qs.size() < DEPTH);
      l_acc   = lsu_v && (ql.size() < DEPTH);
      g_s     = (qs.size() > 0) && ((ql.size() == 0) || m_last_lsu);
      g_l     = (ql.size() > 0) && !g_s;
      m_valid = g_s || g_l;
      m_out   = '0;
      if (g_s) begin
        m_out = qs.pop_front();
        m_last_lsu = 1'b0;
      end else if (g_l) begin
        m_out = ql.pop_front();
        m_last_lsu = 1'b1;
      end
      m_err = (s_acc && simd_m != 4'b0 && !legal(simd_m)) ||
              (l_acc && lsu_m != 4'b0 && !legal(lsu_m));
      if (s_acc && simd_m != 4'b0) qs.push_back('{wf: simd_wf, a: simd_a, m: simd_m});
      if (l_acc && lsu_m != 4'b0)  ql.push_back('{wf: lsu_wf, a: lsu_a, m: lsu_m});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_valid", 32'(o_valid), 32'(m_valid));
      chk("sb_wfid", 32'(o_wfid), 32'(m_out.wf));
      chk("sb_addr", 32'(o_addr), 32'(m_out.a));
      chk("sb_mask", 32'(o_mask), 32'(m_out.m));
      chk("sb_err", 32'(o_err), 32'(m_err));
      chk("sb_simd_ready", 32'(simd_rdy), 32'(qs.size() < DEPTH));
      chk("sb_lsu_ready", 32'(lsu_rdy), 32'(ql.size() < DEPTH));
      chk("sb_idle", 32'(o_idle), 32'(qs.size() == 0 && ql.size() == 0 && !m_valid));
      if (o_valid) dut_log.push_back(o_addr);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_s(input logic v, input logic [5:0] wf, input logic [9:0] a, input logic [3:0] m);
    simd_v = v; simd_wf = wf; simd_a = a; simd_m = m;
  endtask

  task automatic drive_l(input logic v, input logic [5:0] wf, input logic [9:0] a, input logic [3:0] m);
    lsu_v = v; lsu_wf = wf; lsu_a = a; lsu_m = m;
  endtask

  task automatic idle_in();
    simd_v = 1'b0;
    lsu_v  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    tick();
    rst_n = 1'b1;
  endtask

  // Both sources offer a new sequential address every cycle; a sequence number advances only on accept.
  task automatic stream(input int n, input logic [9:0] sb, input logic [9:0] lb, output logic saw_full);
    int   ss = 0;
    int   ls = 0;
    logic sp, lp;
    saw_full = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_s(1'b1, 6'd1, sb + 10'(ss), 4'b0001);
      drive_l(1'b1, 6'd2, lb + 10'(ls), 4'b1111);
      sp = simd_rdy;
      lp = lsu_rdy;
      if (!lsu_rdy) saw_full = 1'b1;
      tick();
      if (sp) ss++;
      if (lp) ls++;
    end
    idle_in();
  endtask

  initial begin
    logic full_seen;
    int   n_simd;

    repeat (2) tick();
    chk_en = 1'b1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_mask", 32'(o_mask), 32'd0);
    chk("rst_idle", 32'(o_idle), 32'd1);
    chk("rst_simd_ready", 32'(simd_rdy), 32'd1);
    chk("rst_lsu_ready", 32'(lsu_rdy), 32'd1);
    rst_n = 1'b1;

    // Single SIMD retire: one-cycle broadcast, then back to zero.
    drive_s(1'b1, 6'd3, 10'h010, 4'b0001);
    tick();
    idle_in();
    chk("t1_not_yet", 32'(o_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(o_valid), 32'd1);
    chk("t1_wfid", 32'(o_wfid), 32'd3);
    chk("t1_addr", 32'(o_addr), 32'h010);
    chk("t1_mask", 32'(o_mask), 32'b0001);
    tick();
    chk("t1_valid_off", 32'(o_valid), 32'd0);
    chk("t1_mask_off", 32'(o_mask), 32'd0);

    // Same-cycle pushes after reset: SIMD first, LSU next.
    do_reset();
    drive_s(1'b1, 6'd4, 10'h020, 4'b0011);
    drive_l(1'b1, 6'd7, 10'h040, 4'b1111);
    tick();
    idle_in();
    tick();
    chk("t2_first_addr", 32'(o_addr), 32'h020);
    chk("t2_first_mask", 32'(o_mask), 32'b0011);
    tick();
    chk("t2_second_addr", 32'(o_addr), 32'h040);
    chk("t2_second_mask", 32'(o_mask), 32'b1111);
    tick();
    chk("t2_done", 32'(o_valid), 32'd0);

    // Saturate both sources until LSU backpressures, then drain.
    do_reset();
    stream(20, 10'h080, 10'h0C0, full_seen);
    chk("t3_lsu_full_seen", 32'(full_seen), 32'd1);
    repeat (12) tick();
    chk("t3_lsu_ready_back", 32'(lsu_rdy), 32'd1);
    chk("t3_idle", 32'(o_idle), 32'd1);

    // Illegal and empty masks.
    do_reset();
    drive_s(1'b1, 6'd5, 10'h123, 4'b0101);
    tick();
    idle_in();
    chk("t4_err_pulse", 32'(o_err), 32'd1);
    tick();
    chk("t4_bad_mask_fwd", 32'(o_mask), 32'b0101);
    chk("t4_err_clear", 32'(o_err), 32'd0);
    drive_s(1'b1, 6'd5, 10'h050, 4'b0000);
    tick();
    idle_in();
    chk("t4_zero_no_err", 32'(o_err), 32'd0);
    tick();
    chk("t4_zero_dropped", 32'(o_valid), 32'd0);
    chk("t4_zero_idle", 32'(o_idle), 32'd1);
    drive_s(1'b1, 6'd1, 10'h011, 4'b0110);
    drive_l(1'b1, 6'd2, 10'h022, 4'b1000);
    tick();
    idle_in();
    chk("t4_dual_err", 32'(o_err), 32'd1);
    tick();
    chk("t4_dual_err_once", 32'(o_err), 32'd0);
    repeat (3) tick();
    drive_l(1'b1, 6'd63, 10'h3FF, 4'b1111);
    tick();
    idle_in();
    tick();
    chk("t4_top_addr", 32'(o_addr), 32'h3FF);
    chk("t4_top_wfid", 32'(o_wfid), 32'd63);

    // Reset with entries queued discards them.
    do_reset();
    repeat (2) begin
      drive_s(1'b1, 6'd9, 10'h1A0, 4'b0001);
      drive_l(1'b1, 6'd9, 10'h2A0, 4'b0011);
      tick();
    end
    chk("t5_pre_not_idle", 32'(o_idle), 32'd0);
    do_reset();
    chk("t5_valid", 32'(o_valid), 32'd0);
    chk("t5_idle", 32'(o_idle), 32'd1);
    chk("t5_simd_ready", 32'(simd_rdy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_stale", 32'(o_valid), 32'd0);
    end

    // Sustained two-source traffic: strict alternation and in-order per source.
    do_reset();
    dut_log.delete();
    stream(16, 10'h100, 10'h200, full_seen);
    repeat (12) tick();
    chk("t6_enough", 32'(dut_log.size() >= 16), 32'd1);
    n_simd = 0;
    for (int i = 0; i < 16; i++) begin
      logic [9:0] a;
      a = (i < dut_log.size()) ? dut_log[i] : 10'h000;
      chk("t6_src", 32'(a[9:8]), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("t6_seq", 32'(a[7:0]), 32'(i / 2));
      if (a[9:8] == 2'd1) n_simd++;
    end
    chk("t6_simd_grants", 32'(n_simd), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
